// File: rtl/mastermind_round_ctrl_if.sv
// mastermind_round_ctrl_if
// Bus between the round controller and the external bank of eight 2-bit
// enabled registers (four secret slots, four guess slots).
//   secret_en : one-hot write enable for the secret registers
//   guess_en  : one-hot write enable for the guess registers
//   reg_d     : shared write data for all eight registers
//   secret_q  : secret register outputs, slot i in bits [2i+1:2i]
//   guess_q   : guess register outputs, same packing
// master = controller side, slave = register bank side.
interface mastermind_round_ctrl_if;
  logic [3:0] secret_en;
  logic [3:0] guess_en;
  logic [1:0] reg_d;
  logic [7:0] secret_q;
  logic [7:0] guess_q;

  modport master (
    output secret_en,
    output guess_en,
    output reg_d,
    input  secret_q,
    input  guess_q
  );

  modport slave (
    input  secret_en,
    input  guess_en,
    input  reg_d,
    output secret_q,
    output guess_q
  );
endinterface

// File: rtl/mastermind_round_ctrl.sv
// mastermind_round_ctrl
// Sequences one Mastermind round: steps secret and guess entry slot by slot,
// drives the one-hot register enables and shared data bus, reads the
// register bank back to score each guess in black/white pegs, counts
// attempts and declares win or loss.
// Ports:
//   CLK         : rising-edge clock
//   reset       : asynchronous active-low reset
//   start       : begins a new game from IDLE, WIN or LOSE
//   push        : accepts color into the current slot (one per high cycle)
//   color       : colour code 0..3
//   bank        : register bank bus (enables, data, register outputs)
//   slot        : next slot to be filled
//   attempts    : guesses scored this game
//   black/white : last score
//   score_valid : one-cycle pulse when black/white update
//   win/lose    : high while in the terminal state
module mastermind_round_ctrl #(
  parameter int MAX_TRIES = 10,
  parameter int ATT_W     = 4
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   push,
  input  logic [1:0]             color,
  mastermind_round_ctrl_if.master bank,
  output logic [1:0]             slot,
  output logic [ATT_W-1:0]       attempts,
  output logic [2:0]             black,
  output logic [2:0]             white,
  output logic                   score_valid,
  output logic                   win,
  output logic                   lose
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SECRET = 3'd1,
    ST_GUESS  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SCORE  = 3'd4,
    ST_WIN    = 3'd5,
    ST_LOSE   = 3'd6
  } state_t;

  // One-hot decode of a slot index.
  function automatic logic [3:0] onehot_f(input logic [1:0] idx);
    onehot_f = 4'b0001 << idx;
  endfunction

  // Peg score: {black[2:0], white[2:0]}. White is the per-colour overlap of
  // both codes minus the exact-position matches.
  function automatic logic [5:0] score_f(input logic [7:0] s, input logic [7:0] g);
    logic [2:0] blk;
    logic [2:0] tot;
    logic [2:0] cs;
    logic [2:0] cg;
    logic [1:0] col;
    blk = 3'd0;
    tot = 3'd0;
    for (int i = 0; i < 4; i++) begin
      blk = blk + ((s[2*i +: 2] == g[2*i +: 2]) ? 3'd1 : 3'd0);
    end
    for (int c = 0; c < 4; c++) begin
      col = c[1:0];
      cs  = 3'd0;
      cg  = 3'd0;
      for (int i = 0; i < 4; i++) begin
        cs = cs + ((s[2*i +: 2] == col) ? 3'd1 : 3'd0);
        cg = cg + ((g[2*i +: 2] == col) ? 3'd1 : 3'd0);
      end
      tot = tot + ((cs < cg) ? cs : cg);
    end
    score_f = {blk, tot - blk};
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [1:0]       slot_r;
  logic [1:0]       slot_nxt_s;
  logic [ATT_W-1:0] attempts_r;
  logic [ATT_W-1:0] attempts_nxt_s;
  logic [ATT_W-1:0] attempts_inc_s;
  logic [2:0]       black_r;
  logic [2:0]       black_nxt_s;
  logic [2:0]       white_r;
  logic [2:0]       white_nxt_s;
  logic             score_valid_r;
  logic             score_valid_nxt_s;
  logic [3:0]       secret_en_r;
  logic [3:0]       secret_en_nxt_s;
  logic [3:0]       guess_en_r;
  logic [3:0]       guess_en_nxt_s;
  logic [1:0]       reg_d_r;
  logic             win_r;
  logic             lose_r;
  logic [5:0]       score_s;

  assign score_s        = score_f(bank.secret_q, bank.guess_q);
  assign attempts_inc_s = attempts_r + ATT_W'(1);

  // Next-state, slot stepping, enable generation and scoring.
  always_comb begin
    state_nxt_s       = state_r;
    slot_nxt_s        = slot_r;
    attempts_nxt_s    = attempts_r;
    black_nxt_s       = black_r;
    white_nxt_s       = white_r;
    score_valid_nxt_s = 1'b0;
    secret_en_nxt_s   = 4'b0000;
    guess_en_nxt_s    = 4'b0000;

    case (state_r)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          state_nxt_s    = ST_SECRET;
          slot_nxt_s     = 2'd0;
          attempts_nxt_s = ATT_W'(0);
          black_nxt_s    = 3'd0;
          white_nxt_s    = 3'd0;
        end else begin
          state_nxt_s = state_r;
        end
      end

      ST_SECRET: begin
        if (push) begin
          secret_en_nxt_s = onehot_f(slot_r);
          slot_nxt_s      = slot_r + 2'd1;
          if (slot_r == 2'd3) begin
            state_nxt_s = ST_GUESS;
          end else begin
            state_nxt_s = ST_SECRET;
          end
        end else begin
          state_nxt_s = ST_SECRET;
        end
      end

      ST_GUESS: begin
        // The last guess enable is still on the bus this cycle; wait for it
        // instead of accepting a new push, then let the register settle.
        if (guess_en_r[3]) begin
          state_nxt_s = ST_SETTLE;
        end else if (push) begin
          guess_en_nxt_s = onehot_f(slot_r);
          slot_nxt_s     = slot_r + 2'd1;
          state_nxt_s    = ST_GUESS;
        end else begin
          state_nxt_s = ST_GUESS;
        end
      end

      ST_SETTLE: begin
        state_nxt_s = ST_SCORE;
      end

      ST_SCORE: begin
        black_nxt_s       = score_s[5:3];
        white_nxt_s       = score_s[2:0];
        attempts_nxt_s    = attempts_inc_s;
        score_valid_nxt_s = 1'b1;
        if (score_s[5:3] == 3'd4) begin
          state_nxt_s = ST_WIN;
        end else if (attempts_inc_s == ATT_W'(MAX_TRIES)) begin
          state_nxt_s = ST_LOSE;
        end else begin
          state_nxt_s = ST_GUESS;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      slot_r        <= 2'd0;
      attempts_r    <= ATT_W'(0);
      black_r       <= 3'd0;
      white_r       <= 3'd0;
      score_valid_r <= 1'b0;
      secret_en_r   <= 4'b0000;
      guess_en_r    <= 4'b0000;
      reg_d_r       <= 2'd0;
      win_r         <= 1'b0;
      lose_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      slot_r        <= slot_nxt_s;
      attempts_r    <= attempts_nxt_s;
      black_r       <= black_nxt_s;
      white_r       <= white_nxt_s;
      score_valid_r <= score_valid_nxt_s;
      secret_en_r   <= secret_en_nxt_s;
      guess_en_r    <= guess_en_nxt_s;
      reg_d_r       <= color;
      win_r         <= (state_nxt_s == ST_WIN);
      lose_r        <= (state_nxt_s == ST_LOSE);
    end
  end

  assign bank.secret_en = secret_en_r;
  assign bank.guess_en  = guess_en_r;
  assign bank.reg_d     = reg_d_r;
  assign slot           = slot_r;
  assign attempts       = attempts_r;
  assign black          = black_r;
  assign white          = white_r;
  assign score_valid    = score_valid_r;
  assign win            = win_r;
  assign lose           = lose_r;

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// tb_mastermind_round_ctrl
// Bench for mastermind_round_ctrl: external register bank, game-level
// reference model, per-cycle compare process and directed scenarios.
module tb_mastermind_round_ctrl;
  localparam int MAX_TRIES = 10;
  localparam int ATT_W     = 4;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             push = 1'b0;
  logic [1:0]       color = 2'd0;
  logic [1:0]       slot;
  logic [ATT_W-1:0] attempts;
  logic [2:0]       black;
  logic [2:0]       white;
  logic             score_valid;
  logic             win;
  logic             lose;

  int tests = 0;
  int fails = 0;

  mastermind_round_ctrl_if bank_if ();

  mastermind_round_ctrl #(.MAX_TRIES(MAX_TRIES), .ATT_W(ATT_W)) dut (
    .CLK(CLK), .reset(reset), .start(start), .push(push), .color(color),
    .bank(bank_if), .slot(slot), .attempts(attempts), .black(black),
    .white(white), .score_valid(score_valid), .win(win), .lose(lose)
  );

  always #5 CLK = ~CLK;

  // External register bank
  logic [7:0] sec_bank = 8'h00;
  logic [7:0] gss_bank = 8'h00;
  always @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (bank_if.secret_en[i]) sec_bank[2*i +: 2] <= bank_if.reg_d;
      if (bank_if.guess_en[i])  gss_bank[2*i +: 2] <= bank_if.reg_d;
    end
  end
  assign bank_if.secret_q = sec_bank;
  assign bank_if.guess_q  = gss_bank;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- game-level reference model ----------------
  // phase: 0 no game running (idle/won/lost), 1 entering secret,
  // 2 entering guess, 3 waiting for the score of a complete guess.
  int         m_phase = 0;
  int         m_pos = 0;
  int         m_wait = 0;
  int         m_att = 0;
  int         m_black = 0;
  int         m_white = 0;
  bit         m_win = 1'b0;
  bit         m_lose = 1'b0;
  bit         m_valid = 1'b0;
  logic [3:0] m_sen = 4'd0;
  logic [3:0] m_gen = 4'd0;
  logic [1:0] m_regd = 2'd0;
  int         m_sec[4];
  int         m_gss[4];

  // Classic peg-marking score: returns black*8 + white.
  function automatic int model_score();
    int b;
    int w;
    bit sm[4];
    bit gm[4];
    bit found;
    b = 0;
    w = 0;
    for (int i = 0; i < 4; i++) begin
      sm[i] = 1'b0;
      gm[i] = 1'b0;
      if (m_sec[i] == m_gss[i]) begin
        b++;
        sm[i] = 1'b1;
        gm[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!gm[i]) begin
        found = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (!found && !sm[j] && m_sec[j] == m_gss[i]) begin
            sm[j] = 1'b1;
            found = 1'b1;
            w++;
          end
        end
      end
    end
    return b * 8 + w;
  endfunction

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_pos <= 0; m_wait <= 0; m_att <= 0;
      m_black <= 0; m_white <= 0; m_win <= 1'b0; m_lose <= 1'b0;
      m_valid <= 1'b0; m_sen <= 4'd0; m_gen <= 4'd0; m_regd <= 2'd0;
    end else begin
      m_valid <= 1'b0;
      m_sen   <= 4'd0;
      m_gen   <= 4'd0;
      m_regd  <= color;
      case (m_phase)
        0: if (start) begin
          m_phase <= 1; m_pos <= 0; m_att <= 0; m_black <= 0; m_white <= 0;
          m_win <= 1'b0; m_lose <= 1'b0;
        end
        1: if (push) begin
          m_sec[m_pos] <= int'(color);
          m_sen <= 4'b0001 << m_pos;
          if (m_pos == 3) begin m_pos <= 0; m_phase <= 2; end
          else m_pos <= m_pos + 1;
        end
        2: if (push) begin
          m_gss[m_pos] <= int'(color);
          m_gen <= 4'b0001 << m_pos;
          if (m_pos == 3) begin m_pos <= 0; m_phase <= 3; m_wait <= 3; end
          else m_pos <= m_pos + 1;
        end
        3: begin
          m_wait <= m_wait - 1;
          if (m_wait == 1) begin
            m_black <= model_score() / 8;
            m_white <= model_score() % 8;
            m_att   <= m_att + 1;
            m_valid <= 1'b1;
            if (model_score() / 8 == 4) begin m_win <= 1'b1; m_phase <= 0; end
            else if (m_att + 1 == MAX_TRIES) begin m_lose <= 1'b1; m_phase <= 0; end
            else m_phase <= 2;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge CLK) begin
    chk("slot", int'(slot), m_pos);
    chk("attempts", int'(attempts), m_att);
    chk("black", int'(black), m_black);
    chk("white", int'(white), m_white);
    chk("score_valid", int'(score_valid), int'(m_valid));
    chk("win", int'(win), int'(m_win));
    chk("lose", int'(lose), int'(m_lose));
    chk("secret_en", int'(bank_if.secret_en), int'(m_sen));
    chk("guess_en", int'(bank_if.guess_en), int'(m_gen));
    chk("reg_d", int'(bank_if.reg_d), int'(m_regd));
    chk("enable_onehot", int'($countones({bank_if.secret_en, bank_if.guess_en}) <= 1), 1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_pulse();
    @(negedge CLK); start = 1'b1; push = 1'b0;
    @(negedge CLK); start = 1'b0;
  endtask

  // Pushes four colours back to back (slot i from cols[2i+1:2i]); ends on
  // the negedge of the cycle carrying the 4th enable with push = hold.
  task automatic push_four(input logic [7:0] cols, input bit hold);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); push = 1'b1; color = cols[2*i +: 2];
    end
    @(negedge CLK); push = hold;
  endtask

  // Counts negedges until score_valid, bounded.
  task automatic wait_score(output int n);
    n = 0;
    while (score_valid !== 1'b1 && n < 20) begin
      @(negedge CLK); n++;
    end
    chk("score_wait_bound", int'(score_valid), 1);
  endtask

  int         n;
  int         k;
  logic [1:0] cols8[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_slot", int'(slot), 0);
    chk("rst_attempts", int'(attempts), 0);
    chk("rst_enables", int'({bank_if.secret_en, bank_if.guess_en}), 0);
    chk("rst_flags", int'({score_valid, win, lose, black, white}), 0);
    @(negedge CLK); @(negedge CLK); reset = 1'b1;

    // push ignored before start
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); push = 1'b1; color = 2'd2;
      chk("idle_push_en", int'({bank_if.secret_en, bank_if.guess_en}), 0);
    end
    push = 1'b0;

    // Game 1: eight consecutive pushes, secret 0,1,2,3 then guess 3,2,1,0
    start_pulse();
    cols8 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i <= 8; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        chk("seq_secret_en", int'(bank_if.secret_en), (i - 1 < 4) ? (1 << (i - 1)) : 0);
        chk("seq_guess_en", int'(bank_if.guess_en), (i - 1 >= 4) ? (1 << (i - 5)) : 0);
        chk("seq_reg_d", int'(bank_if.reg_d), int'(cols8[i-1]));
      end
      if (i < 8) begin push = 1'b1; color = cols8[i]; end
      else push = 1'b0;
    end
    wait_score(n);
    chk("g1_latency", n, 3);
    chk("g1_black", int'(black), 0);
    chk("g1_white", int'(white), 4);
    chk("g1_attempts", int'(attempts), 1);
    chk("g1_secret_q", int'(bank_if.secret_q), 8'hE4);
    chk("g1_guess_q", int'(bank_if.guess_q), 8'h1B);
    chk("model_g1_white", m_white, 4);
    @(negedge CLK);
    chk("g1_valid_pulse", int'(score_valid), 0);

    // start ignored in GUESS
    start = 1'b1; @(negedge CLK); start = 1'b0;
    chk("start_ignored", int'(attempts), 1);

    // reset mid-GUESS at slot 2
    push = 1'b1; color = 2'd1; @(negedge CLK);
    color = 2'd2; @(negedge CLK);
    push = 1'b0;
    chk("pre_rst_slot", int'(slot), 2);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_slot", int'(slot), 0);
    chk("mid_rst_attempts", int'(attempts), 0);
    chk("mid_rst_enables", int'({bank_if.secret_en, bank_if.guess_en}), 0);
    chk("mid_rst_flags", int'({score_valid, win, lose, black, white}), 0);
    @(negedge CLK); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; color = 2'd3; @(negedge CLK);
      chk("post_rst_slot", int'(slot), 0);
      chk("post_rst_en", int'({bank_if.secret_en, bank_if.guess_en}), 0);
    end
    push = 1'b0;

    // Game 2: guess 0,0,1,1 then winning guess
    start_pulse();
    push_four(8'hE4, 1'b0);
    push_four(8'h50, 1'b0);
    wait_score(n);
    chk("g2a_black", int'(black), 1);
    chk("g2a_white", int'(white), 1);
    chk("model_g2a_black", m_black, 1);
    push_four(8'hE4, 1'b0);
    wait_score(n);
    chk("g2b_black", int'(black), 4);
    chk("g2b_white", int'(white), 0);
    chk("g2b_win", int'(win), 1);
    chk("g2b_attempts", int'(attempts), 2);
    push_four(8'h00, 1'b0);
    chk("g2_after_win", int'(win), 1);
    chk("g2_after_attempts", int'(attempts), 2);
    chk("g2_after_black", int'(black), 4);

    // Game 3: secret 3,2,1,0 then push held at colour 0 until loss
    start_pulse();
    push_four(8'h1B, 1'b1);
    wait_score(n);
    chk("g3_first_black", int'(black), 1);
    chk("g3_first_white", int'(white), 0);
    chk("g3_score_guess_en", int'(bank_if.guess_en), 0);
    chk("g3_score_slot", int'(slot), 0);
    @(negedge CLK);
    chk("g3_reaccept_en", int'(bank_if.guess_en), 1);
    k = 0;
    while (lose !== 1'b1 && k < 200) begin
      @(negedge CLK); k++;
    end
    chk("g3_lose", int'(lose), 1);
    chk("g3_attempts", int'(attempts), 10);
    chk("model_g3_attempts", m_att, 10);
    @(negedge CLK); @(negedge CLK);
    chk("g3_lose_hold", int'(lose), 1);
    chk("g3_push_ignored", int'({bank_if.secret_en, bank_if.guess_en}), 0);
    start_pulse();
    chk("g3_restart_attempts", int'(attempts), 0);
    chk("g3_restart_lose", int'(lose), 0);
    push = 1'b1; color = 2'd2; @(negedge CLK); push = 1'b0;
    chk("g3_restart_secret_en", int'(bank_if.secret_en), 1);
    chk("g3_restart_reg_d", int'(bank_if.reg_d), 2);
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mastermind_round_ctrl.md
# mastermind_round_ctrl

Sequencing controller for one Mastermind round over a bank of eight external 2-bit enabled registers: four hold the secret code, four hold the current guess. It steps code entry slot by slot, drives the one-hot register enables and shared data bus, then reads the register outputs back to score each guess as black and white pegs. It also counts attempts and declares a win or a loss. It sits between the player-input front end and the display/result logic.

## Interface
- `MAX_TRIES`, default 10, number of scored guesses before loss (1..15).
- `ATT_W`, default 4, attempt counter width; must satisfy 2^ATT_W > MAX_TRIES.
- `CLK`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; clears all state and outputs.
- `start`  in  1  level sampled per cycle; begins a new game from IDLE, WIN or LOSE.
- `push`  in  1  accepts `color` into the current slot; one accept per high cycle.
- `color`  in  2  colour code 0..3 for the current slot.
- `secret_q`  in  8  secret register outputs; slot i is bits [2i+1:2i].
- `guess_q`  in  8  guess register outputs; same packing.
- `secret_en`  out  4  one-hot secret register enable.
- `guess_en`  out  4  one-hot guess register enable.
- `reg_d`  out  2  data to every register; it is the registered copy of `color`.
- `slot`  out  2  next slot to be filled.
- `attempts`  out  ATT_W  number of guesses scored this game.
- `black`  out  3  correct colour in the correct position (0..4).
- `white`  out  3  correct colour in the wrong position (0..4).
- `score_valid`  out  1  one-cycle pulse when `black`/`white` update.
- `win`, `lose`  out  1  each holds high while in its terminal state.

## Operation
- States: IDLE, SECRET, GUESS, SETTLE, SCORE, WIN, LOSE.
- Reset: state IDLE. All outputs are 0, including `slot`, `attempts`, `black`, `white` and all enables.
- IDLE/WIN/LOSE + `start`:
  - Next state is SECRET.
  - `slot`, `attempts`, `black` and `white` clear to 0.
  - `win`/`lose` drop.
  - `push` is ignored in these states.
- SECRET + `push`:
  - Next cycle, `secret_en` is the one-hot of `slot` and `reg_d` is `color`.
  - `slot` increments.
  - On the push at slot 3, `slot` wraps to 0 and state becomes GUESS.
- GUESS + `push`:
  - Same as SECRET, but drives `guess_en`.
  - On the push at slot 3, `slot` wraps to 0 and state becomes SETTLE.
- SETTLE: one cycle in which the last guess register captures its data. Then state becomes SCORE.
- SCORE: one cycle. Computed from `secret_q`/`guess_q` and registered:
  - black = number of positions i with equal slot values.
  - white = sum over colours c of min(count_secret(c), count_guess(c)) − black.
  - `attempts` increments.
  - Next state: WIN if black == 4. Else LOSE if the new `attempts` == MAX_TRIES. Else GUESS.
- `start` outside IDLE/WIN/LOSE is ignored. There is no abort other than `reset`.
- `push` in SETTLE or SCORE is ignored and is not buffered.
- Enables are never asserted in the same cycle as another enable. At most one bit of the 8 is high.

## Timing
- Push latency: `push` sampled at edge t produces the enable and `reg_d` during cycle t+1. The register output is valid from t+2.
- Back-to-back pushes are all accepted, one slot per cycle, with enables in consecutive cycles.
- Scoring latency: with the 4th guess push at edge t:
  - enable in t+1;
  - SETTLE in t+2;
  - SCORE in t+3;
  - `black`, `white`, `score_valid`=1, updated `attempts` and the new state (`win`/`lose`) are all visible in t+4.
- `black`/`white` hold their value until the next SCORE or a new game.
- A `push` arriving at t+4 after a non-terminal score is accepted as guess slot 0.
- `reset` assertion at any point, including mid-entry or in SCORE: outputs clear asynchronously and no enable pulse completes. After release, the first edge is in IDLE.

## Test plan
- Reset mid-GUESS at slot 2 → all outputs 0 and state IDLE. After release, `push` is ignored until `start`.
- Secret 0,1,2,3 (`secret_q`=8'hE4), guess 3,2,1,0 → black 0, white 4, `attempts`=1, `score_valid` pulses exactly once, 3 cycles after the enable.
- Same secret, guess 0,0,1,1 → black 1, white 1. Then guess 0,1,2,3 → black 4, `win`=1, `attempts`=2. A later `push` has no effect.
- Ten wrong guesses with MAX_TRIES=10 → `lose`=1 and `attempts`=10 in the cycle after the 10th SCORE. Then `start` → SECRET, `attempts`=0.
- Eight consecutive `push` cycles after `start` → `secret_en` 0001, 0010, 0100, 1000 then `guess_en` 0001..1000 on successive cycles. `reg_d` tracks `color` delayed one cycle.
- `push` held high through SETTLE/SCORE → no enables in those cycles, `slot` stays 0, and the first accept occurs in the cycle GUESS is re-entered.
